gauss_row_sequencer: RTL and testbench

Sequencer for the single-pass GF(p) systemizer array built from `processor_AB` cells. It fetches matrix rows from row memory and streams them into column 0 of the array with the start, first-pass and finish markers. It then flushes the array with zero rows so the accumulated pivot rows drain out, and generates write-back addresses for the drained rows. It reports `done` and whether the matrix was fully systemizable.

---
 rtl/gauss_row_if.sv | 39 +++
 rtl/gauss_row_sequencer.sv | 152 +++++++++++++++
 tb/tb_gauss_row_sequencer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/gauss_row_if.sv
// gauss_row_if: bundles the run handshake, row-memory read port, array
// column-0 slot controls and write-back strobe of gauss_row_sequencer.
//   slave  modport: the sequencer (drives everything except start/arr_r_flags)
//   master modport: the controller/array side
interface gauss_row_if #(
  parameter int N_ROWS = 16,
  parameter int N_COLS = 8,
  parameter int AW     = $clog2(N_ROWS),
  parameter int OW     = (N_COLS > 1) ? $clog2(N_COLS) : 1
) ();
  logic              start;
  logic              busy;
  logic              done;
  logic              success;
  logic              mem_rd_en;
  logic [AW-1:0]     mem_rd_addr;
  logic              arr_valid;
  logic              arr_start;
  logic              arr_first_pass;
  logic              arr_finish;
  logic              arr_zero;
  logic [N_COLS-1:0] arr_r_flags;
  logic              out_valid;
  logic [OW-1:0]     out_addr;

  modport slave (
    input  start, arr_r_flags,
    output busy, done, success, mem_rd_en, mem_rd_addr,
           arr_valid, arr_start, arr_first_pass, arr_finish, arr_zero,
           out_valid, out_addr
  );

  modport master (
    output start, arr_r_flags,
    input  busy, done, success, mem_rd_en, mem_rd_addr,
           arr_valid, arr_start, arr_first_pass, arr_finish, arr_zero,
           out_valid, out_addr
  );
endinterface

// File: rtl/gauss_row_sequencer.sv
// gauss_row_sequencer: drives the single-pass GF(p) systemizer array.
// Streams N_ROWS memory rows into column 0 (start/first-pass markers), then
// N_COLS zero flush slots (finish/zero), and raises out_valid/out_addr as the
// pivot rows drain out PIPE_LAT cycles after each flush slot.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   bus       - gauss_row_if.slave (start/busy/done/success, mem_rd_*,
//               arr_*, arr_r_flags, out_valid/out_addr)
// Optional: define GAUSS_RANK_CHECK_EN to derive success from the diagonal
// r flags sampled on the first flush slot; otherwise success is always 1.
module gauss_row_sequencer #(
  parameter int N_ROWS   = 16,
  parameter int N_COLS   = 8,
  parameter int PIPE_LAT = 8,
  parameter int AW       = $clog2(N_ROWS),
  parameter int OW       = (N_COLS > 1) ? $clog2(N_COLS) : 1
) (
  input  logic     clk,
  input  logic     rst,
  gauss_row_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FEED, S_FLUSH, S_DRAIN, S_DONE
  } state_t;

  localparam logic [AW-1:0] ADDR_LAST = AW'(N_ROWS - 1);
  localparam logic [OW-1:0] COL_LAST  = OW'(N_COLS - 1);

  state_t state, nxt;

  logic [AW-1:0]       addr;
  logic [OW-1:0]       flush_cnt;
  logic [OW-1:0]       out_cnt;
  logic [PIPE_LAT-1:0] drain_pipe;   // flush slot markers travelling through the array
  logic                accept;

  // slot fields before the alignment register
  logic slot_v, slot_start, slot_fp, slot_fin;

  assign accept = (state == S_IDLE) && bus.start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt        = state;
    slot_v     = 1'b0;
    slot_start = 1'b0;
    slot_fp    = 1'b0;
    slot_fin   = 1'b0;
    unique case (state)
      S_IDLE:  if (bus.start) nxt = S_FEED;
      S_FEED: begin
        slot_v     = 1'b1;
        slot_fp    = 1'b1;
        slot_start = (addr == '0);
        if (addr == ADDR_LAST) nxt = S_FLUSH;
      end
      S_FLUSH: begin
        slot_v   = 1'b1;
        slot_fin = 1'b1;
        if (flush_cnt == COL_LAST) nxt = S_DRAIN;
      end
      // the last drained word can only land after FLUSH has ended
      S_DRAIN: if (bus.out_valid && out_cnt == COL_LAST) nxt = S_DONE;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  assign bus.busy        = (state == S_FEED) || (state == S_FLUSH) || (state == S_DRAIN);
  assign bus.done        = (state == S_DONE);
  assign bus.mem_rd_en   = (state == S_FEED);
  assign bus.mem_rd_addr = addr;
  assign bus.out_addr    = out_cnt;
  assign bus.out_valid   = drain_pipe[PIPE_LAT-1];
  assign bus.arr_zero    = bus.arr_finish;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr      <= '0;
      flush_cnt <= '0;
    end else begin
      if (state == S_FEED)  addr      <= (addr == ADDR_LAST)     ? '0 : addr + AW'(1);
      if (state == S_FLUSH) flush_cnt <= (flush_cnt == COL_LAST) ? '0 : flush_cnt + OW'(1);
    end
  end

  // out_valid may already fire during FLUSH for short pipelines, so the
  // output counter follows out_valid rather than the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                out_cnt <= '0;
    else if (accept)        out_cnt <= '0;
    else if (bus.out_valid) out_cnt <= (out_cnt == COL_LAST) ? '0 : out_cnt + OW'(1);
  end

  // slot register: aligns markers with the 1-cycle memory read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.arr_valid      <= 1'b0;
      bus.arr_start      <= 1'b0;
      bus.arr_first_pass <= 1'b0;
      bus.arr_finish     <= 1'b0;
    end else begin
      bus.arr_valid      <= slot_v;
      bus.arr_start      <= slot_start;
      bus.arr_first_pass <= slot_fp;
      bus.arr_finish     <= slot_fin;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drain_pipe <= '0;
    else begin
      drain_pipe[0] <= bus.arr_finish;
      for (int i = 1; i < PIPE_LAT; i++) drain_pipe[i] <= drain_pipe[i-1];
    end
  end

  logic rank_ok;

`ifdef GAUSS_RANK_CHECK_EN
  logic              first_fin;   // registered alongside arr_finish: first flush slot
  logic [N_COLS-1:0] flags_cap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_fin <= 1'b0;
      flags_cap <= '0;
    end else begin
      first_fin <= (state == S_FLUSH) && (flush_cnt == '0);
      if (first_fin) flags_cap <= bus.arr_r_flags;
    end
  end

  assign rank_ok = &flags_cap;
`else
  logic unused_flags;
  assign unused_flags = ^bus.arr_r_flags;
  assign rank_ok      = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   bus.success <= 1'b0;
    else if (accept)                           bus.success <= 1'b0;
    else if (state == S_DRAIN && nxt == S_DONE) bus.success <= rank_ok;
  end

endmodule

// File: tb/tb_gauss_row_sequencer.sv
// tb_gauss_row_sequencer: directed checks of gauss_row_sequencer with
// N_ROWS=4, N_COLS=2, PIPE_LAT=3 (run length D=11). Cycle 0 is the cycle
// in which start is sampled; signals are observed at the falling edge.
module tb_gauss_row_sequencer;
  localparam int NR = 4, NC = 2, PL = 3;

  logic clk, rst;
  int   n_vec, n_err;

  gauss_row_if #(.N_ROWS(NR), .N_COLS(NC)) bus ();

  gauss_row_sequencer #(.N_ROWS(NR), .N_COLS(NC), .PIPE_LAT(PL)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // {busy,done,rd_en,valid,start,first_pass,finish,zero,out_valid}
  function automatic logic [8:0] exp_bits(input int c);
    case (c)
      1:       return 9'b1_0_1_0_0_0_0_0_0;
      2:       return 9'b1_0_1_1_1_1_0_0_0;
      3, 4:    return 9'b1_0_1_1_0_1_0_0_0;
      5:       return 9'b1_0_0_1_0_1_0_0_0;
      6, 7:    return 9'b1_0_0_1_0_0_1_1_0;
      8:       return 9'b1_0_0_0_0_0_0_0_0;
      9, 10:   return 9'b1_0_0_0_0_0_0_0_1;
      11:      return 9'b0_1_0_0_0_0_0_0_0;
      default: return 9'b0;
    endcase
  endfunction

  function automatic logic [8:0] obs_bits();
    return {bus.busy, bus.done, bus.mem_rd_en, bus.arr_valid, bus.arr_start,
            bus.arr_first_pass, bus.arr_finish, bus.arr_zero, bus.out_valid};
  endfunction

  // Caller sits at the falling edge of cycle 0; returns at the falling edge of cycle 12.
  task automatic do_run(input string nm, input logic [1:0] flags, input logic hold);
    logic exp_succ;
`ifdef GAUSS_RANK_CHECK_EN
    exp_succ = (flags == 2'b11);
`else
    exp_succ = 1'b1;
`endif
    bus.start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (!hold) bus.start = 1'b0;
      bus.arr_r_flags = (c == 6) ? flags : 2'b00;
      chk($sformatf("%s c%0d ctl", nm, c), 32'(obs_bits()), 32'(exp_bits(c)));
      if (c >= 1 && c <= 4)
        chk($sformatf("%s c%0d rd_addr", nm, c), 32'(bus.mem_rd_addr), 32'(c - 1));
      if (c == 9 || c == 10)
        chk($sformatf("%s c%0d out_addr", nm, c), 32'(bus.out_addr), 32'(c - 9));
      if (c == 1)
        chk($sformatf("%s c1 succ_clr", nm), 32'(bus.success), 32'(0));
      if (c == 11 || c == 12)
        chk($sformatf("%s c%0d success", nm, c), 32'(bus.success), 32'(exp_succ));
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.arr_r_flags = '0;
    #12;
    chk("rst idle ctl", 32'(obs_bits()), 32'(0));
    chk("rst idle succ", 32'(bus.success), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post rst ctl", 32'(obs_bits()), 32'(0));

    // nominal, rank-full flags
    do_run("nom", 2'b11, 1'b0);
    @(negedge clk);
    // rank-deficient flags
    do_run("def", 2'b01, 1'b0);

    // back-to-back: second start in cycle 12
    do_run("b2b0", 2'b11, 1'b0);
    do_run("b2b1", 2'b11, 1'b0);

    // start held throughout: second run's rd_en in cycle 13
    do_run("hold0", 2'b11, 1'b1);
    do_run("hold1", 2'b11, 1'b1);
    bus.start = 1'b0;
    @(negedge clk);
    chk("hold end idle", 32'(obs_bits()), 32'(0));

    // async reset mid-run in cycle 5
    bus.start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    chk("abort c5 busy", 32'(bus.busy), 32'(1));
    rst = 1'b1;
    #1;
    chk("abort async ctl", 32'(obs_bits()), 32'(0));
    chk("abort async addr", 32'(bus.mem_rd_addr), 32'(0));
    chk("abort async succ", 32'(bus.success), 32'(0));
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort c6 ctl", 32'(obs_bits()), 32'(0));
    @(negedge clk);
    chk("abort c7 ctl", 32'(obs_bits()), 32'(0));
    // restart in cycle 7: this run's cycle 11 is absolute cycle 18
    do_run("rstrt", 2'b11, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
